// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// word-length encodings, parity-mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  // Unused upper data bits must already be 0 so they do not disturb the XOR.
  function automatic logic expected_parity(input logic [7:0] data,
                                           input logic       even,
                                           input logic       stick);
    logic p;
    if (stick) begin
      p = ~even;
    end else if (even == PAR_EVEN) begin
      p = ^data;
    end else begin
      p = ~(^data);
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator: one pulse every max(divisor,1) clocks.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] reload_s;
  logic                 tick_r;

  // Reload value; a divisor of 0 behaves like 1 (tick every clock).
  always_comb begin
    if (divisor == {DIV_WIDTH{1'b0}}) begin
      reload_s = {DIV_WIDTH{1'b0}};
    end else begin
      reload_s = divisor - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Down-counter; the divisor is only looked at on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {DIV_WIDTH{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == {DIV_WIDTH{1'b0}}) begin
      cnt_r  <= reload_s;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, oversampled majority-vote bit decision,
// framing/parity/break checks and a one-word valid/ready output holding stage.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic                 i_rx,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic [1:0]           i_word_len,
  input  logic                 i_parity_en,
  input  logic                 i_parity_even,
  input  logic                 i_parity_stick,
  input  logic                 i_ready,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int              PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_A    = PH_W'(OVERSAMPLE/2 - 1);
  localparam logic [PH_W-1:0] PH_B    = PH_W'(OVERSAMPLE/2);
  localparam logic [PH_W-1:0] PH_C    = PH_W'(OVERSAMPLE/2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  uart_state_t     state_r, next_state_s;
  logic            sync1_r, sync2_r, rx_d_r;
  logic            rx_s, fall_s, tick_s, sample_pt_s, maj_s;
  logic            last_bit_s, frame_done_s;
  logic [PH_W-1:0] phase_r;
  logic            smp_a_r, smp_b_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            par_bit_r;
  logic            par_err_s, break_s;
  logic [7:0]      data_r;
  logic            valid_r, perr_r, ferr_r, brk_r, ovr_r, busy_r;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk     (i_sys_clk),
    .rst_n   (i_sys_rst_n),
    .divisor (i_divisor),
    .tick    (tick_s)
  );

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      rx_d_r  <= 1'b1;
    end else begin
      sync1_r <= i_rx;
      sync2_r <= sync1_r;
      rx_d_r  <= sync2_r;
    end
  end

  assign rx_s         = sync2_r;
  assign fall_s       = rx_d_r & ~sync2_r;
  assign sample_pt_s  = tick_s && (phase_r == PH_C);
  assign maj_s        = (smp_a_r & smp_b_r) | (smp_a_r & rx_s) | (smp_b_r & rx_s);
  assign last_bit_s   = ({1'b0, bit_cnt_r} >= ({2'b00, i_word_len} + 4'd4));
  assign frame_done_s = (state_r == ST_STOP) && sample_pt_s;
  assign par_err_s    = i_parity_en &&
                        (par_bit_r != expected_parity(shift_r, i_parity_even, i_parity_stick));
  assign break_s      = ~maj_s && (shift_r == 8'h00) && (~i_parity_en || ~par_bit_r);

  // Tick phase within a bit; it keeps running across bits so state changes can happen mid-bit.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      phase_r <= {PH_W{1'b0}};
      smp_a_r <= 1'b1;
      smp_b_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && fall_s) begin
      phase_r <= {PH_W{1'b0}};
    end else if (tick_s) begin
      phase_r <= (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + {{(PH_W-1){1'b0}}, 1'b1};
      if (phase_r == PH_A) smp_a_r <= rx_s;
      if (phase_r == PH_B) smp_b_r <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; every bit decision happens at the third majority sample.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) next_state_s = ST_START;
        else        next_state_s = ST_IDLE;
      end
      ST_START: begin
        if (sample_pt_s) next_state_s = maj_s ? ST_IDLE : ST_DATA;
        else             next_state_s = ST_START;
      end
      ST_DATA: begin
        if (sample_pt_s && last_bit_s) next_state_s = i_parity_en ? ST_PARITY : ST_STOP;
        else                           next_state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (sample_pt_s) next_state_s = ST_STOP;
        else             next_state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (sample_pt_s) next_state_s = maj_s ? ST_IDLE : ST_WAIT_IDLE;
        else             next_state_s = ST_STOP;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) next_state_s = ST_IDLE;
        else      next_state_s = ST_WAIT_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Data and parity capture; the shift register is cleared so unused upper bits read 0.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_bit_r <= 1'b0;
    end else if ((state_r == ST_START) && sample_pt_s) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_bit_r <= 1'b0;
    end else if ((state_r == ST_DATA) && sample_pt_s) begin
      shift_r[bit_cnt_r] <= maj_s;
      bit_cnt_r          <= bit_cnt_r + 3'd1;
    end else if ((state_r == ST_PARITY) && sample_pt_s) begin
      par_bit_r <= maj_s;
    end
  end

  // Output holding stage: a completed frame is dropped (overrun) only if the held word is stuck.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      brk_r   <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      if (frame_done_s && (!valid_r || i_ready)) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
        perr_r  <= par_err_s;
        ferr_r  <= ~maj_s;
        brk_r   <= break_s;
        ovr_r   <= 1'b0;
      end else if (frame_done_s) begin
        ovr_r <= 1'b1;
      end else if (valid_r && i_ready) begin
        valid_r <= 1'b0;
        ovr_r   <= 1'b0;
      end
    end
  end

  assign o_data       = data_r;
  assign o_valid      = valid_r;
  assign o_parity_err = perr_r;
  assign o_frame_err  = ferr_r;
  assign o_break      = brk_r;
  assign o_overrun    = ovr_r;
  assign o_busy       = busy_r;

endmodule
